// File: rtl/inv_mix_columns_iter.sv
`default_nettype none
// ============================================================================
//  Module      : inv_mix_columns_iter
//  Description : Iterative AES InvMixColumns engine. It accepts one 128-bit
//                state over a valid/ready handshake and transforms one 32-bit
//                column per clock in place, using a single shared column
//                datapath. The result is held on data_out until the
//                downstream stage takes it.
//
//  Ports       : clk        - sole clock, rising edge
//                rst_n      - asynchronous active-low reset
//                in_valid   - data_in holds a valid state
//                in_ready   - block can accept a state (IDLE only)
//                data_in    - state in; column c = [127-32c -: 32],
//                             byte s0 in the top 8 bits of each column
//                out_valid  - data_out holds a completed result (DONE only)
//                out_ready  - downstream accepts data_out
//                data_out   - transformed state, same layout as data_in
//
//  Revision    : 1.0 - initial release
// ============================================================================
module inv_mix_columns_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    // Low byte of the AES reduction polynomial 0x11B.
    localparam logic [7:0] C_POLY = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     cnt_q,   cnt_d;
    logic [127:0]   work_q,  work_d;

    logic [31:0]    col_in;
    logic [31:0]    col_out;
    logic [127:0]   work_wr;

    // Multiply by x in GF(2^8).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? C_POLY : 8'h00);
    endfunction

    // ------------------------------------------------------------------
    // Column select: the counter picks which column feeds the datapath.
    // ------------------------------------------------------------------
    always_comb begin
        col_in = work_q[127:96];
        case (cnt_q)
            2'd0:    col_in = work_q[127:96];
            2'd1:    col_in = work_q[95:64];
            2'd2:    col_in = work_q[63:32];
            default: col_in = work_q[31:0];
        endcase
    end

    // ------------------------------------------------------------------
    // Shared column datapath. Each byte gets an xtime chain (x2, x4, x8);
    // the four InvMixColumns coefficients are XOR combinations of it:
    //   09 = 8+1, 0B = 8+2+1, 0D = 8+4+1, 0E = 8+4+2
    // ------------------------------------------------------------------
    logic [7:0] s_b  [4];
    logic [7:0] x2_b [4];
    logic [7:0] x4_b [4];
    logic [7:0] x8_b [4];
    logic [7:0] m9_b [4];
    logic [7:0] mb_b [4];
    logic [7:0] md_b [4];
    logic [7:0] me_b [4];

    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign s_b[i]  = col_in[31-8*i -: 8];
        assign x2_b[i] = xtime(s_b[i]);
        assign x4_b[i] = xtime(x2_b[i]);
        assign x8_b[i] = xtime(x4_b[i]);
        assign m9_b[i] = x8_b[i] ^ s_b[i];
        assign mb_b[i] = x8_b[i] ^ x2_b[i] ^ s_b[i];
        assign md_b[i] = x8_b[i] ^ x4_b[i] ^ s_b[i];
        assign me_b[i] = x8_b[i] ^ x4_b[i] ^ x2_b[i];
    end

    // Output row i is a circulant: 0E on s[i], 0B on s[i+1], 0D on s[i+2],
    // 09 on s[i+3] (indices mod 4).
    for (genvar i = 0; i < 4; i++) begin : g_row
        assign col_out[31-8*i -: 8] = me_b[i]
                                    ^ mb_b[(i+1)%4]
                                    ^ md_b[(i+2)%4]
                                    ^ m9_b[(i+3)%4];
    end

    // ------------------------------------------------------------------
    // In-place write-back of the transformed column.
    // ------------------------------------------------------------------
    always_comb begin
        work_wr = work_q;
        case (cnt_q)
            2'd0:    work_wr[127:96] = col_out;
            2'd1:    work_wr[95:64]  = col_out;
            2'd2:    work_wr[63:32]  = col_out;
            default: work_wr[31:0]   = col_out;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM: next state and register updates.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d  = data_in;
                    cnt_d   = 2'd0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                work_d = work_wr;
                // Wraps 3 -> 0 so the next block starts at column 0.
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            work_q  <= 128'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    // Handshake outputs decode registered state only.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign data_out  = work_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_mix_columns_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inv_mix_columns_iter
//  Description : Self-checking bench for inv_mix_columns_iter. Expected
//                results come from a matrix-level GF(2^8) reference model
//                and are queued at accept time; a monitor pops and compares
//                on every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_mix_columns_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = 0;
    logic [127:0] exp_q[$];

    inv_mix_columns_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: generic GF(2^8) multiply and circulant matrix.
    // ------------------------------------------------------------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] coef(input bit inv, input int idx);
        case (idx)
            0:       return inv ? 8'h0E : 8'h02;
            1:       return inv ? 8'h0B : 8'h03;
            2:       return inv ? 8'h0D : 8'h01;
            default: return inv ? 8'h09 : 8'h01;
        endcase
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] st, input bit inv);
        logic [127:0] res = 128'h0;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(coef(inv, (k - r + 4) % 4), st[127-32*c-8*k -: 8]);
                res[127-32*c-8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: compare on each output handshake.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0)
                chk("unexpected_out_valid", 128'd1, 128'd0);
            else
                chk("data_out", data_out, exp_q.pop_front());
        end
    end

    // Present d until accepted; queue e at the accept edge. Returns #1
    // after the accept edge.
    task automatic issue(input logic [127:0] d, input logic [127:0] e, input bit hold);
        int guard = 0;
        in_valid = 1'b1;
        data_in  = d;
        while (!in_ready) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 100) begin
                chk("accept_timeout", 128'd0, 128'd1);
                in_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        last_acc = cyc;
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("drain_empty", 128'(exp_q.size()), 128'd0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] v, e, st;
        int first_acc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        data_in   = 128'h0;
        out_ready = 1'b0;
        #1;
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_data_out", data_out, 128'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Known vector: latency and in_ready profile.
        out_ready = 1'b1;
        v = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
        e = 128'hdb135345_f20a225c_01010101_2d26314c;
        chk("model_known_vector", ref_mix(v, 1'b1), e);
        issue(v, e, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("in_ready_T%0d", k), 128'(in_ready), 128'd0);
            chk($sformatf("out_valid_T%0d", k), 128'(out_valid), 128'(k == 4));
        end
        chk("known_data_T4", data_out, e);
        @(posedge clk); #1;
        chk("in_ready_after_T5", 128'(in_ready), 128'd1);
        chk("out_valid_after_T5", 128'(out_valid), 128'd0);
        chk("data_out_kept", data_out, e);

        // Identity columns.
        issue(128'hc6c6c6c6_01010101_d5d5d7d6_00000000,
              128'hc6c6c6c6_01010101_d4d4d4d5_00000000, 1'b0);
        drain();

        // Backpressure with toggling inputs.
        out_ready = 1'b0;
        v = rnd128();
        e = ref_mix(v, 1'b1);
        issue(v, e, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            chk("bp_data_stable", data_out, e);
            in_valid = $urandom_range(0, 1);
            data_in  = rnd128();
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", 128'(in_ready), 128'd1);
        chk("bp_release_out_valid", 128'(out_valid), 128'd0);
        chk("bp_release_queue", 128'(exp_q.size()), 128'd0);

        // Back-to-back with in_valid held high.
        v = rnd128();
        issue(v, ref_mix(v, 1'b1), 1'b1);
        first_acc = last_acc;
        v = rnd128();
        issue(v, ref_mix(v, 1'b1), 1'b1);
        in_valid = 1'b0;
        chk("b2b_spacing", 128'(last_acc - first_acc), 128'd6);
        drain();

        // Reset mid-BUSY.
        v = rnd128();
        issue(v, ref_mix(v, 1'b1), 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_busy_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy_data_out", data_out, 128'h0);
        chk("rst_busy_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset while DONE under backpressure: out_valid must drop at once.
        out_ready = 1'b0;
        v = rnd128();
        issue(v, ref_mix(v, 1'b1), 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_done_out_valid", 128'(out_valid), 128'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_done_out_valid", 128'(out_valid), 128'd0);
        chk("rst_done_data_out", data_out, 128'h0);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("post_rst_no_out_valid", 128'(out_valid), 128'd0);
            chk("post_rst_in_ready", 128'(in_ready), 128'd1);
        end

        // Random states directly against the inverse model.
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            v = rnd128();
            issue(v, ref_mix(v, 1'b1), 1'b0);
        end

        // Round trip: forward MixColumns model then this block.
        for (int n = 0; n < 1000; n++) begin
            st = rnd128();
            issue(ref_mix(st, 1'b0), st, $urandom_range(0, 1) == 1);
        end
        in_valid = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
